// File: rtl/iiitb_lfsr_gen.sv
// rtl/iiitb_lfsr_gen.sv - parametrised Fibonacci/Galois LFSR with lockup recovery and period monitor

module iiitb_lfsr_gen #(
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   TAPS  = 8'h1D,
    parameter logic [WIDTH-1:0]   SEED  = 8'h01
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             mode,
    output logic [WIDTH-1:0] state,
    output logic             out_bit,
    output logic             lockup,
    output logic             wrap,
    output logic [WIDTH-1:0] period
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] step_cnt;

    logic             fib_fb;
    logic [WIDTH-1:0] fib_next;
    logic [WIDTH-1:0] gal_next;
    logic             is_zero;
    logic [WIDTH-1:0] step_next;

    // Next-state candidates for both forms; an all-zero state is replaced by SEED
    always_comb begin
        fib_fb    = ^(q & TAPS);
        fib_next  = {fib_fb, q[WIDTH-1:1]};
        gal_next  = {q[0], q[WIDTH-1:1] ^ (TAPS[WIDTH-1:1] & {(WIDTH-1){q[0]}})};
        is_zero   = (q == '0);
        step_next = is_zero ? SEED : (mode ? gal_next : fib_next);
    end

    // State, reference, step counter, period and one-cycle event pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q        <= SEED;
            ref_q    <= SEED;
            step_cnt <= '0;
            period   <= '0;
            lockup   <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            lockup <= 1'b0;
            wrap   <= 1'b0;
            if (load) begin
                q        <= seed;
                ref_q    <= seed;
                step_cnt <= '0;
            end else if (en) begin
                q      <= step_next;
                lockup <= is_zero;
                if (step_next == ref_q) begin
                    wrap     <= 1'b1;
                    period   <= step_cnt + WIDTH'(1);
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + WIDTH'(1);
                end
            end
        end
    end

    assign state   = q;
    assign out_bit = q[0];

endmodule

// File: tb/tb_iiitb_lfsr_gen.sv
// tb/tb_iiitb_lfsr_gen.sv - scoreboard bench for iiitb_lfsr_gen in 4-bit and default 8-bit configs

module tb_iiitb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] en, load, mode;
    logic [3:0] seed4;
    logic [7:0] seed8;

    logic [3:0] state4, period4;
    logic       out4, lk4, wr4;
    logic [7:0] state8, period8;
    logic       out8, lk8, wr8;

    iiitb_lfsr_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h8)) dut4 (
        .clk(clk), .reset_n(reset_n), .en(en[0]), .load(load[0]), .seed(seed4),
        .mode(mode[0]), .state(state4), .out_bit(out4), .lockup(lk4), .wrap(wr4),
        .period(period4)
    );

    iiitb_lfsr_gen dut8 (
        .clk(clk), .reset_n(reset_n), .en(en[1]), .load(load[1]), .seed(seed8),
        .mode(mode[1]), .state(state8), .out_bit(out8), .lockup(lk8), .wrap(wr8),
        .period(period8)
    );

    typedef struct {
        int          inst;
        logic [31:0] st;
        logic        lk;
        logic        wr;
        logic [31:0] per;
    } exp_t;

    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_q[2], m_ref[2], m_cnt[2], m_per[2];

    logic [31:0] fib_tab[16];
    logic [31:0] gal_tab[6];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int wof(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic logic [31:0] tapsof(input int i);
        return (i == 0) ? 32'h3 : 32'h1D;
    endfunction

    function automatic logic [31:0] seedof(input int i);
        return (i == 0) ? 32'h8 : 32'h1;
    endfunction

    function automatic logic [31:0] maskof(input int i);
        return (32'h1 << wof(i)) - 32'h1;
    endfunction

    function automatic logic [31:0] model_next(input int i, input logic [31:0] q, input logic md);
        logic [31:0] n;
        logic        fb;
        if (!md) begin
            fb = ^(q & tapsof(i));
            n  = (q >> 1) | ({31'h0, fb} << (wof(i) - 1));
        end else begin
            n = q >> 1;
            if (q[0]) n = n ^ ((tapsof(i) >> 1) | (32'h1 << (wof(i) - 1)));
        end
        return n & maskof(i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i]   = seedof(i);
            m_ref[i] = seedof(i);
            m_cnt[i] = 0;
            m_per[i] = 0;
        end
    endtask

    task automatic read_obs(input int i, output logic [31:0] st, output logic lk,
                            output logic wr, output logic [31:0] per, output logic ob);
        if (i == 0) begin
            st = {28'h0, state4}; lk = lk4; wr = wr4; per = {28'h0, period4}; ob = out4;
        end else begin
            st = {24'h0, state8}; lk = lk8; wr = wr8; per = {24'h0, period8}; ob = out8;
        end
    endtask

    task automatic cyc(input int i, input logic e, input logic l, input logic [31:0] s, input logic md);
        exp_t        x;
        logic [31:0] n, st, per;
        logic        lk, wr, ob;
        en      = 2'b00;
        load    = 2'b00;
        en[i]   = e;
        load[i] = l;
        mode[i] = md;
        if (i == 0) seed4 = s[3:0]; else seed8 = s[7:0];
        x.inst = i; x.lk = 1'b0; x.wr = 1'b0;
        if (l) begin
            m_q[i]   = s & maskof(i);
            m_ref[i] = m_q[i];
            m_cnt[i] = 0;
        end else if (e) begin
            x.lk = (m_q[i] == 0);
            n = x.lk ? seedof(i) : model_next(i, m_q[i], md);
            if (n == m_ref[i]) begin
                x.wr     = 1'b1;
                m_per[i] = (m_cnt[i] + 1) & maskof(i);
                m_cnt[i] = 0;
            end else begin
                m_cnt[i] = (m_cnt[i] + 1) & maskof(i);
            end
            m_q[i] = n;
        end
        x.st  = m_q[i];
        x.per = m_per[i];
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'h0, 32'h1);
        end else begin
            x = exp_q.pop_front();
            read_obs(x.inst, st, lk, wr, per, ob);
            chk("state", st, x.st);
            chk("out_bit", {31'h0, ob}, {31'h0, x.st[0]});
            chk("lockup", {31'h0, lk}, {31'h0, x.lk});
            chk("wrap", {31'h0, wr}, {31'h0, x.wr});
            chk("period", per, x.per);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_state4", {28'h0, state4}, 32'h8);
        chk("rst_period4", {28'h0, period4}, 32'h0);
        chk("rst_lk4", {31'h0, lk4}, 32'h0);
        chk("rst_wr4", {31'h0, wr4}, 32'h0);
        chk("rst_state8", {24'h0, state8}, 32'h1);
        chk("rst_period8", {24'h0, period8}, 32'h0);
        chk("rst_lk8", {31'h0, lk8}, 32'h0);
        chk("rst_wr8", {31'h0, wr8}, 32'h0);
    endtask

    initial begin
        int wraps;
        fib_tab = '{32'h8, 32'h4, 32'h2, 32'h9, 32'hC, 32'h6, 32'hB, 32'h5,
                    32'hA, 32'hD, 32'hE, 32'hF, 32'h7, 32'h3, 32'h1, 32'h8};
        gal_tab = '{32'h8, 32'h4, 32'h2, 32'h1, 32'h9, 32'hD};

        reset_n = 1'b0;
        en = 2'b00; load = 2'b00; mode = 2'b00; seed4 = 4'h0; seed8 = 8'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        #2 reset_n = 1'b1;

        // Fibonacci 4-bit: fixed sequence and period 15
        for (int k = 0; k < 15; k++) begin
            cyc(0, 1'b1, 1'b0, 0, 1'b0);
            chk("fib4_table", {28'h0, state4}, fib_tab[k+1]);
            chk("fib4_wrap_at15", {31'h0, wr4}, (k == 14) ? 32'h1 : 32'h0);
        end
        chk("fib4_period", {28'h0, period4}, 32'd15);

        // Galois 4-bit
        for (int k = 0; k < 15; k++) begin
            cyc(0, 1'b1, 1'b0, 0, 1'b1);
            if (k < 5) chk("gal4_table", {28'h0, state4}, gal_tab[k+1]);
        end
        chk("gal4_period", {28'h0, period4}, 32'd15);

        // Default 8-bit, both modes: one wrap per 255 steps
        for (int md = 0; md < 2; md++) begin
            wraps = 0;
            for (int k = 0; k < 255; k++) begin
                cyc(1, 1'b1, 1'b0, 0, md[0]);
                if (wr8) wraps++;
            end
            chk("def8_wraps", wraps, 1);
            chk("def8_period", {24'h0, period8}, 32'hFF);
        end

        // Zero seed load then lockup recovery; load beats en
        cyc(0, 1'b0, 1'b1, 0, 1'b0);
        chk("zero_load_state", {28'h0, state4}, 32'h0);
        cyc(0, 1'b1, 1'b0, 0, 1'b0);
        chk("lockup_pulse", {31'h0, lk4}, 32'h1);
        chk("lockup_state", {28'h0, state4}, 32'h8);
        cyc(0, 1'b1, 1'b0, 0, 1'b0);
        chk("lockup_single", {31'h0, lk4}, 32'h0);
        cyc(0, 1'b1, 1'b1, 32'h5, 1'b0);
        chk("load_wins", {28'h0, state4}, 32'h5);

        // en toggling 1,0,0,1 across a full period
        cyc(0, 1'b0, 1'b1, 32'h8, 1'b0);
        for (int k = 0; k < 15; k++) begin
            cyc(0, 1'b1, 1'b0, 0, 1'b0);
            if (k < 14) begin
                cyc(0, 1'b0, 1'b0, 0, 1'b0);
                cyc(0, 1'b0, 1'b0, 0, 1'b0);
            end
        end
        chk("toggle_period", {28'h0, period4}, 32'd15);
        chk("toggle_state", {28'h0, state4}, 32'h8);

        // Async reset during the wrap pulse
        cyc(0, 1'b0, 1'b1, 32'h8, 1'b0);
        for (int k = 0; k < 15; k++) cyc(0, 1'b1, 1'b0, 0, 1'b0);
        chk("pre_rst_wrap", {31'h0, wr4}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk_reset_vals();
        #3 reset_n = 1'b1;

        // Async reset mid-sequence, then restart from SEED
        for (int k = 0; k < 5; k++) cyc(0, 1'b1, 1'b0, 0, 1'b0);
        chk("pre_rst_state", {28'h0, state4}, fib_tab[5]);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk_reset_vals();
        @(posedge clk);
        #1;
        chk_reset_vals();
        #3 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1'b1, 1'b0, 0, 1'b0);
            chk("restart_table", {28'h0, state4}, fib_tab[k+1]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
